// File: rtl/chunked_addsub_if.sv
// Handshake bus for chunked_addsub_unit: operand request side and result/flag side.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface chunked_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ctrl;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_gt;
  logic             flag_carry;
  logic             flag_ovf;
  logic             out_illegal;
  logic             busy;

  modport master (
    output in_valid, a, b, ctrl, signed_mode, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_gt, flag_carry,
           flag_ovf, out_illegal, busy
  );

  modport slave (
    input  in_valid, a, b, ctrl, signed_mode, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_gt, flag_carry,
           flag_ovf, out_illegal, busy
  );
endinterface

// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/sub/compare unit: one CHUNK-bit slice per clock, LSB first,
// carry registered between slices; result and flags registered on the final slice.
module chunked_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  chunked_addsub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_addsub_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;        // already inverted for SUB/CMP
  logic [WIDTH-1:0] sum_reg;
  logic [1:0]       op_reg;
  logic             signed_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;

  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             gt_reg;
  logic             carry_out_reg;
  logic             ovf_reg;
  logic             illegal_reg;

  logic [CHUNK-1:0] a_slices [NCHUNK];
  logic [CHUNK-1:0] b_slices [NCHUNK];
  logic [CHUNK:0]   slice_ext;
  logic [WIDTH-1:0] full_sum;
  logic             last_slice;
  logic             in_is_sub;

  // full_sum is the accumulated sum with the current slice merged in, so the
  // flags on the final edge see the complete word.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_slices[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign full_sum[gi*CHUNK +: CHUNK] =
        (cnt_reg == CW'(gi)) ? slice_ext[CHUNK-1:0] : sum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_comb begin
    slice_ext = {1'b0, a_slices[cnt_reg]} + {1'b0, b_slices[cnt_reg]}
              + {{CHUNK{1'b0}}, carry_reg};
  end

  assign last_slice = (cnt_reg == CW'(NCHUNK - 1));
  assign in_is_sub  = (bus.ctrl == OP_SUB) || (bus.ctrl == OP_CMP);

  logic sum_msb;
  logic carry_final;
  logic zero_c;
  logic ovf_c;
  logic gt_c;
  logic op_is_add;
  logic op_is_rsv;

  always_comb begin
    sum_msb     = full_sum[WIDTH-1];
    carry_final = slice_ext[CHUNK];
    zero_c      = (full_sum == '0);
    ovf_c       = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_msb != a_reg[WIDTH-1]);
    op_is_add   = (op_reg == OP_ADD);
    op_is_rsv   = (op_reg == OP_RSV);
    // Signed greater-than: nonzero difference with N == V.
    if (signed_reg) gt_c = ~zero_c & (sum_msb == ovf_c);
    else            gt_c = carry_final & ~zero_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      op_reg        <= 2'b00;
      signed_reg    <= 1'b0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      gt_reg        <= 1'b0;
      carry_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.a;
            b_reg        <= in_is_sub ? ~bus.b : bus.b;
            carry_reg    <= in_is_sub;
            op_reg       <= bus.ctrl;
            signed_reg   <= bus.signed_mode;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_reg   <= full_sum;
          carry_reg <= slice_ext[CHUNK];
          if (last_slice) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            illegal_reg   <= op_is_rsv;
            if (op_is_rsv) begin
              result_reg    <= '0;
              zero_reg      <= 1'b0;
              gt_reg        <= 1'b0;
              carry_out_reg <= 1'b0;
              ovf_reg       <= 1'b0;
            end else begin
              result_reg    <= op_is_add ? full_sum : ((op_reg == OP_SUB) ? full_sum : '0);
              zero_reg      <= zero_c;
              gt_reg        <= op_is_add ? 1'b0 : gt_c;
              carry_out_reg <= carry_final;
              ovf_reg       <= ovf_c;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.busy        = busy_reg;
  assign bus.result      = result_reg;
  assign bus.flag_zero   = zero_reg;
  assign bus.flag_gt     = gt_reg;
  assign bus.flag_carry  = carry_out_reg;
  assign bus.flag_ovf    = ovf_reg;
  assign bus.out_illegal = illegal_reg;

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Directed bench for chunked_addsub_unit: full-width reference model feeds a
// scoreboard queue; results are popped and checked when out_valid appears.
module tb_chunked_addsub_unit;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             gt;
    logic             carry;
    logic             ovf;
    logic             ill;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

  chunked_addsub_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model works on the whole word at once.
  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sm);
    exp_t e;
    logic [WIDTH:0] ext;
    logic           sub;
    logic           sa, sbb, ss;
    sub = (op == 2'b01) || (op == 2'b10);
    e.ill = (op == 2'b11);
    if (sub) ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    else     ext = {1'b0, a} + {1'b0, b};
    sa = a[WIDTH-1]; sbb = b[WIDTH-1]; ss = ext[WIDTH-1];
    if (e.ill) begin
      e.result = '0; e.zero = 0; e.gt = 0; e.carry = 0; e.ovf = 0;
    end else begin
      e.result = (op == 2'b10) ? '0 : ext[WIDTH-1:0];
      e.carry  = ext[WIDTH];
      e.zero   = sub ? (a == b) : (ext[WIDTH-1:0] == '0);
      e.ovf    = sub ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
      if (!sub)    e.gt = 1'b0;
      else if (sm) e.gt = ($signed(a) > $signed(b));
      else         e.gt = (a > b);
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sm, input int hold);
    exp_t e;
    int   cycles;
    check("in_ready_idle", WIDTH'(bus.in_ready), WIDTH'(1));
    sb.push_back(model(op, a, b, sm));
    bus.a = a; bus.b = b; bus.ctrl = op; bus.signed_mode = sm; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = '1; bus.b = '1; bus.ctrl = 2'b00;  // must be ignored during RUN
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      check("in_ready_run", WIDTH'(bus.in_ready), WIDTH'(0));
      check("busy_run", WIDTH'(bus.busy), WIDTH'(1));
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", WIDTH'(cycles), WIDTH'(NCHUNK));
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
      check("result", bus.result, e.result);
      check("flag_zero", WIDTH'(bus.flag_zero), WIDTH'(e.zero));
      check("flag_gt", WIDTH'(bus.flag_gt), WIDTH'(e.gt));
      check("flag_carry", WIDTH'(bus.flag_carry), WIDTH'(e.carry));
      check("flag_ovf", WIDTH'(bus.flag_ovf), WIDTH'(e.ovf));
      check("out_illegal", WIDTH'(bus.out_illegal), WIDTH'(e.ill));
      check("in_ready_done", WIDTH'(bus.in_ready), WIDTH'(0));
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", WIDTH'(bus.out_valid), WIDTH'(0));
    check("in_ready_back", WIDTH'(bus.in_ready), WIDTH'(1));
    check("busy_idle", WIDTH'(bus.busy), WIDTH'(0));
    $display("op=%0d a=0x%08h b=0x%08h sm=%0d -> result=0x%08h z=%0d gt=%0d c=%0d v=%0d ill=%0d",
             op, a, b, sm, e.result, e.zero, e.gt, e.carry, e.ovf, e.ill);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ctrl = 2'b00;
    bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    check("rst_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    check("rst_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("rst_result", bus.result, '0);
    check("rst_illegal", WIDTH'(bus.out_illegal), WIDTH'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    check("tp1_result", bus.result, 32'h0000_0100);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check("tp2_carry", WIDTH'(bus.flag_carry), WIDTH'(1));
    run_op(2'b01, 32'd5, 32'd7, 1'b0, 0);
    check("tp3_result", bus.result, 32'hFFFF_FFFE);
    run_op(2'b01, 32'd7, 32'd5, 1'b0, 0);
    run_op(2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0);
    check("tp4_gt_signed", WIDTH'(bus.flag_gt), WIDTH'(1));
    run_op(2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(2'b10, 32'h0000_1234, 32'h0000_1234, 1'b1, 0);
    run_op(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    check("tp5_ovf", WIDTH'(bus.flag_ovf), WIDTH'(1));
    run_op(2'b11, 32'h1234_5678, 32'h0000_0001, 1'b0, 0);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 3);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    run_op(2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
    run_op(2'b00, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 0);

    // Abandon an operation with reset during its second RUN cycle.
    bus.a = 32'h1; bus.b = 32'h2; bus.ctrl = 2'b00; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrun_busy", WIDTH'(bus.busy), WIDTH'(0));
    check("midrun_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    check("midrun_out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", WIDTH'(bus.out_valid), WIDTH'(0));
    end
    run_op(2'b01, 32'd100, 32'd42, 1'b0, 0);
    check("post_rst_queue_empty", WIDTH'(sb.size()), WIDTH'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_addsub_unit.md
Name: chunked_addsub_unit

Overview:
Multi-cycle, parametrised add/subtract/compare unit that processes operands in CHUNK-bit slices, LSB first, one slice per clock, with the carry held in a register between slices. It is the next generation of the single-cycle integer adder. It adds signed compare, an overflow flag and valid/ready handshakes on both sides. The execute stage uses it where a full-width carry chain would break timing.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, slice width processed per cycle. WIDTH % CHUNK must equal 0; elaboration error otherwise.
NCHUNK, WIDTH/CHUNK, derived slice count. Not overridable.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  operand request.
in_ready  out  1  unit can accept operands.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
ctrl  in  2  operation: 00 ADD, 01 SUB, 10 CMP, 11 reserved.
signed_mode  in  1  1 = two's-complement compare for flag_gt.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  A+B or A-B; forced to 0 for CMP and reserved.
flag_zero  out  1  A-B==0 for SUB/CMP; result==0 for ADD.
flag_gt  out  1  A>B for SUB/CMP; 0 for ADD.
flag_carry  out  1  carry out of the MSB. For SUB/CMP, 1 means no borrow.
flag_ovf  out  1  signed overflow of the add/sub.
out_illegal  out  1  ctrl was 11.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, takes effect immediately): state=IDLE; all outputs 0 except in_ready=1. Slice counter, carry register and operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the unit latches a, b, ctrl and signed_mode.
  - Carry-in is initialised: 0 for ADD, 1 for SUB/CMP. B is inverted for SUB/CMP, giving A + ~B + 1.
  - Counter set to 0; next state RUN.
- RUN:
  - Each edge computes slice k = {carry, sum[CHUNK-1:0]} = A[k] + B'[k] + carry, stores the sum slice and updates the carry.
  - After slice NCHUNK-1 the next state is DONE.
  - in_ready=0 throughout. Inputs are ignored.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge (4 for defaults). Flags are computed on the final slice edge and registered together with the result.
- Flags:
  - flag_carry = final carry.
  - flag_ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
  - Unsigned: flag_gt = flag_carry & ~flag_zero.
  - Signed: flag_gt = ~flag_zero & (sum[MSB]==flag_ovf).
  - flag_zero is always derived from the internal sum, even when result is forced to 0.
- Reserved ctrl=11: runs the full latency, then result=0, all four flags 0, out_illegal=1.
- DONE:
  - out_valid=1. result, flags and out_illegal are held stable until out_ready=1.
  - On an edge with out_ready=1, next state is IDLE and out_valid drops.
  - in_ready stays 0 in DONE; there is no same-cycle accept. The minimum issue interval is NCHUNK+2 cycles.
- Outputs are not cleared on return to IDLE; they keep the last values, but only out_valid qualifies them.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid pulse occurs, and the reset values apply.
- NCHUNK=1 is legal: RUN lasts one edge.

Test Plan:
1. ADD a=0x000000FF, b=0x00000001 -> after 4 edges out_valid=1, result=0x00000100, zero=0, carry=0, ovf=0; in_ready=0 during RUN.
2. ADD a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, zero=1, carry=1, ovf=0, gt=0. Checks carry propagation across all slices.
3. SUB a=5, b=7, signed_mode=0 -> result=0xFFFFFFFE, carry=0, gt=0, zero=0. SUB a=7, b=5 -> result=2, carry=1, gt=1.
4. CMP a=0x00000001, b=0xFFFFFFFF: signed_mode=1 -> gt=1, result=0; signed_mode=0 -> gt=0, carry=0. CMP a=b=0x1234 -> zero=1, gt=0.
5. SUB a=0x7FFFFFFF, b=0xFFFFFFFF, signed -> result=0x80000000, ovf=1, gt=1. ctrl=11 -> result=0, flags 0, out_illegal=1 after 4 edges.
6. Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next edge. Assert rst during the second RUN cycle -> busy=0 and in_ready=1 immediately, no out_valid afterwards.
